// File: rtl/ball_sequencer.sv
// ---------------------------------------------------------------------------
// ball_sequencer
//   Moves a single ball around the play field at one pixel per motion tick,
//   bounces it off the top/bottom/left walls and off the paddle on the right,
//   counts misses in a thermometer-coded score and sequences the game
//   through serve, play, miss hold-off and game-over.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | ball parked at (64,32) dir (1,1), waiting for start
//   PLAY  | ball moves one pixel per tick on both axes
//   MISS  | ball frozen for MISS_TICKS ticks, then re-served from home
//   OVER  | ball frozen after the fourth miss, waiting for clr_score
//
// Ports
//   pixel_clk        in   clock, all state updates on rising edge
//   resetn           in   asynchronous active-low reset
//   start            in   serve request, only looked at in IDLE
//   clr_score        in   synchronous score clear (also leaves OVER)
//   paddle_y[10:0]   in   paddle top line (8..408)
//   ball_x/ball_y    out  ball top-left pixel
//   dir_x/dir_y      out  1 = moving +1 px per tick, 0 = -1 px per tick
//   score[7:0]       out  thermometer miss count, two bits per miss
//   state[1:0]       out  IDLE=0 PLAY=1 MISS=2 OVER=3
//   miss             out  one-cycle pulse on a detected miss
//   tick             out  one-cycle motion-tick pulse
// ---------------------------------------------------------------------------
module ball_sequencer #(
    parameter int TICK_DIV   = 131072,
    parameter int MISS_TICKS = 64
) (
    input  logic        pixel_clk,
    input  logic        resetn,
    input  logic        start,
    input  logic        clr_score,
    input  logic [10:0] paddle_y,
    output logic [10:0] ball_x,
    output logic [10:0] ball_y,
    output logic        dir_x,
    output logic        dir_y,
    output logic [7:0]  score,
    output logic [1:0]  state,
    output logic        miss,
    output logic        tick
);

    localparam int CNT_W  = $clog2(TICK_DIV);
    localparam int MISS_W = (MISS_TICKS > 1) ? $clog2(MISS_TICKS) : 1;

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TICK_DIV - 1);
    localparam logic [MISS_W-1:0] HOLD_LAST = MISS_W'(MISS_TICKS - 1);

    localparam logic [10:0] HOME_X = 11'd64;
    localparam logic [10:0] HOME_Y = 11'd32;
    localparam logic [10:0] X_MIN  = 11'd8;
    localparam logic [10:0] X_PAD  = 11'd600;
    localparam logic [10:0] X_OUT  = 11'd624;
    localparam logic [10:0] Y_MIN  = 11'd8;
    localparam logic [10:0] Y_MAX  = 11'd462;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_MISS = 2'd2,
        S_OVER = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               tick_q, tick_d;
    logic               miss_q, miss_d;
    logic [10:0]        ball_x_q, ball_x_d;
    logic [10:0]        ball_y_q, ball_y_d;
    logic               dir_x_q, dir_x_d;
    logic               dir_y_q, dir_y_d;
    logic [7:0]         score_q, score_d;
    logic [MISS_W-1:0]  hold_q, hold_d;

    logic        tick_now;
    logic        start_acc;
    logic        miss_hit;
    logic        hold_done;
    logic [7:0]  score_upd;
    logic [11:0] paddle_bot;
    logic        in_paddle;
    logic        flip_x;
    logic        flip_y;
    logic        nx_dir_x;
    logic        nx_dir_y;

    // ---------------------------------------------------------------------
    // Shared qualifiers
    // ---------------------------------------------------------------------
    assign tick_now  = (cnt_q == CNT_LAST);
    assign start_acc = (state_q == S_IDLE) && start;
    assign miss_hit  = (state_q == S_PLAY) && tick_now &&
                       (ball_x_q == X_OUT) && dir_x_q;
    assign hold_done = (state_q == S_MISS) && tick_now && (hold_q == '0);
    assign score_upd = (score_q == 8'h00) ? 8'h03 : {score_q[5:0], 2'b11};

    // Paddle window is computed one bit wider so a paddle near the bottom
    // cannot wrap the upper bound.
    assign paddle_bot = {1'b0, paddle_y} + 12'd64;
    assign in_paddle  = ({1'b0, ball_y_q} > {1'b0, paddle_y}) &&
                        ({1'b0, ball_y_q} < paddle_bot);

    assign flip_y = ((ball_y_q == Y_MIN) && !dir_y_q) ||
                    ((ball_y_q == Y_MAX) &&  dir_y_q);
    assign flip_x = ((ball_x_q == X_MIN) && !dir_x_q) ||
                    ((ball_x_q == X_PAD) &&  dir_x_q && in_paddle);
    assign nx_dir_x = dir_x_q ^ flip_x;
    assign nx_dir_y = dir_y_q ^ flip_y;

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    always_ff @(posedge pixel_clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            tick_q   <= 1'b0;
            miss_q   <= 1'b0;
            ball_x_q <= HOME_X;
            ball_y_q <= HOME_Y;
            dir_x_q  <= 1'b1;
            dir_y_q  <= 1'b1;
            score_q  <= 8'h00;
            hold_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            tick_q   <= tick_d;
            miss_q   <= miss_d;
            ball_x_q <= ball_x_d;
            ball_y_q <= ball_y_d;
            dir_x_q  <= dir_x_d;
            dir_y_q  <= dir_y_d;
            score_q  <= score_d;
            hold_q   <= hold_d;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (start) state_d = S_PLAY;
            S_PLAY: begin
                // A same-cycle clear keeps the score at zero, so it can
                // never reach game-over on that miss.
                if (miss_hit) begin
                    state_d = (!clr_score && (score_upd == 8'hFF)) ? S_OVER : S_MISS;
                end
            end
            S_MISS: if (hold_done) state_d = S_PLAY;
            S_OVER: if (clr_score) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // Datapath / output logic
    // ---------------------------------------------------------------------
    always_comb begin
        ball_x_d = ball_x_q;
        ball_y_d = ball_y_q;
        dir_x_d  = dir_x_q;
        dir_y_d  = dir_y_q;
        hold_d   = hold_q;
        miss_d   = 1'b0;

        // Counter restarts on serve so the first move is a full period away.
        if (start_acc || tick_now) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        tick_d = (cnt_d == CNT_LAST);

        if (clr_score) begin
            score_d = 8'h00;
        end else if (miss_hit) begin
            score_d = score_upd;
        end else begin
            score_d = score_q;
        end

        unique case (state_q)
            S_IDLE: begin
                ball_x_d = HOME_X;
                ball_y_d = HOME_Y;
                dir_x_d  = 1'b1;
                dir_y_d  = 1'b1;
            end
            S_PLAY: begin
                if (miss_hit) begin
                    miss_d = 1'b1;
                    hold_d = HOLD_LAST;
                end else if (tick_now) begin
                    dir_x_d  = nx_dir_x;
                    dir_y_d  = nx_dir_y;
                    ball_x_d = nx_dir_x ? ball_x_q + 11'd1 : ball_x_q - 11'd1;
                    ball_y_d = nx_dir_y ? ball_y_q + 11'd1 : ball_y_q - 11'd1;
                end
            end
            S_MISS: begin
                if (hold_done) begin
                    ball_x_d = HOME_X;
                    ball_y_d = HOME_Y;
                    dir_x_d  = 1'b1;
                    dir_y_d  = 1'b1;
                end else if (tick_now) begin
                    hold_d = hold_q - MISS_W'(1);
                end
            end
            S_OVER: begin
                if (clr_score) begin
                    ball_x_d = HOME_X;
                    ball_y_d = HOME_Y;
                    dir_x_d  = 1'b1;
                    dir_y_d  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign ball_x = ball_x_q;
    assign ball_y = ball_y_q;
    assign dir_x  = dir_x_q;
    assign dir_y  = dir_y_q;
    assign score  = score_q;
    assign state  = state_q;
    assign miss   = miss_q;
    assign tick   = tick_q;

endmodule

// File: tb/tb_ball_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ball_sequencer
//   Random-stimulus bench for ball_sequencer with TICK_DIV=4, MISS_TICKS=2.
//   A behavioural game model (integer ball position, signed step per axis,
//   miss count instead of a score register) predicts every output every
//   cycle. Paddle placement is steered when the ball arrives at x=600 so
//   that hits, the window edges and misses all occur.
// ---------------------------------------------------------------------------
module tb_ball_sequencer;

    localparam int TD = 4;
    localparam int MT = 2;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic        clr_score;
    logic [10:0] paddle_y;
    logic [10:0] ball_x;
    logic [10:0] ball_y;
    logic        dir_x;
    logic        dir_y;
    logic [7:0]  score;
    logic [1:0]  state;
    logic        miss;
    logic        tick;

    ball_sequencer #(
        .TICK_DIV   (TD),
        .MISS_TICKS (MT)
    ) dut (
        .pixel_clk (clk),
        .resetn    (resetn),
        .start     (start),
        .clr_score (clr_score),
        .paddle_y  (paddle_y),
        .ball_x    (ball_x),
        .ball_y    (ball_y),
        .dir_x     (dir_x),
        .dir_y     (dir_y),
        .score     (score),
        .state     (state),
        .miss      (miss),
        .tick      (tick)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_st, m_x, m_y, m_dx, m_dy, m_n, m_phase, m_left, m_miss, m_tick;
    int m_total_miss = 0;
    int overs = 0;
    int saw_hit = 0, saw_edge_nohit = 0, saw_clr_miss = 0, saw_miss = 0;
    int clr_miss_done = 0;
    int pad_locked = 0;

    task automatic model_reset();
        m_st = 0; m_x = 64; m_y = 32; m_dx = 1; m_dy = 1;
        m_n = 0; m_phase = 0; m_left = 0; m_miss = 0; m_tick = 0;
    endtask

    task automatic go_home();
        m_x = 64; m_y = 32; m_dx = 1; m_dy = 1;
    endtask

    task automatic model_step(input int st_in, input int clr_in, input int pad);
        int t;
        int nphase;
        t = (m_phase == TD - 1);
        nphase = (m_st == 0 && st_in != 0) ? 0 : (m_phase + 1) % TD;
        m_miss = 0;
        case (m_st)
            0: if (st_in != 0) m_st = 1;
            1: if (t) begin
                if (m_x == 624 && m_dx > 0) begin
                    m_miss = 1;
                    saw_miss = 1;
                    m_total_miss++;
                    m_n = (clr_in != 0) ? 0 : ((m_n < 4) ? m_n + 1 : 4);
                    if (clr_in != 0) saw_clr_miss = 1;
                    m_st = (m_n == 4) ? 3 : 2;
                    if (m_st == 3) overs++;
                    m_left = MT;
                end else begin
                    if ((m_y == 8 && m_dy < 0) || (m_y == 462 && m_dy > 0)) m_dy = -m_dy;
                    if (m_x == 600 && m_dx > 0) begin
                        if (m_y > pad && m_y < pad + 64) saw_hit = 1;
                        else if (m_y == pad || m_y == pad + 64) saw_edge_nohit = 1;
                    end
                    if ((m_x == 8 && m_dx < 0) ||
                        (m_x == 600 && m_dx > 0 && m_y > pad && m_y < pad + 64)) m_dx = -m_dx;
                    m_x += m_dx;
                    m_y += m_dy;
                end
            end
            2: if (t) begin
                m_left--;
                if (m_left == 0) begin
                    go_home();
                    m_st = 1;
                end
            end
            default: if (clr_in != 0) begin
                m_st = 0;
                go_home();
            end
        endcase
        if (clr_in != 0) m_n = 0;
        m_phase = nphase;
        m_tick = (m_phase == TD - 1);
    endtask

    task automatic compare_all();
        check_eq("state",  32'(state),  32'(m_st));
        check_eq("ball_x", 32'(ball_x), 32'(m_x));
        check_eq("ball_y", 32'(ball_y), 32'(m_y));
        check_eq("dir_x",  32'(dir_x),  (m_dx > 0) ? 32'd1 : 32'd0);
        check_eq("dir_y",  32'(dir_y),  (m_dy > 0) ? 32'd1 : 32'd0);
        check_eq("score",  32'(score),  32'((1 << (2 * m_n)) - 1));
        check_eq("miss",   32'(miss),   32'(m_miss));
        check_eq("tick",   32'(tick),   32'(m_tick));
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_state"},  32'(state),  32'd0);
        check_eq({tag, "_ball_x"}, 32'(ball_x), 32'd64);
        check_eq({tag, "_ball_y"}, 32'(ball_y), 32'd32);
        check_eq({tag, "_dir_x"},  32'(dir_x),  32'd1);
        check_eq({tag, "_dir_y"},  32'(dir_y),  32'd1);
        check_eq({tag, "_score"},  32'(score),  32'd0);
        check_eq({tag, "_miss"},   32'(miss),   32'd0);
        check_eq({tag, "_tick"},   32'(tick),   32'd0);
    endtask

    task automatic choose_inputs();
        start = ($urandom_range(0, 3) == 0);
        clr_score = 1'b0;
        if (m_st == 3) begin
            clr_score = ($urandom_range(0, 19) == 0);
        end else if (m_st == 1 && m_phase == TD - 1 && m_x == 624 && m_dx > 0 &&
                     m_total_miss == 1 && clr_miss_done == 0) begin
            clr_score = 1'b1;
            clr_miss_done = 1;
        end
        if (m_st == 1 && m_x == 600 && m_dx > 0) begin
            if (pad_locked == 0) begin
                int r;
                int off;
                int p;
                r = $urandom_range(0, 9);
                case (r)
                    0:       off = 63;
                    1:       off = $urandom_range(1, 62);
                    2, 3, 4: off = 0;
                    5, 6, 7: off = 64;
                    default: off = 1000;
                endcase
                p = m_y - off;
                if (p < 8 || p > 408) p = $urandom_range(8, 408);
                paddle_y = 11'(p);
            end
            pad_locked = 1;
        end else begin
            pad_locked = 0;
            if ($urandom_range(0, 15) == 0) paddle_y = 11'($urandom_range(8, 408));
        end
    endtask

    initial begin
        int did_rst;
        int done;
        did_rst = 0;
        done = 0;
        resetn = 1'b1;
        start = 1'b0;
        clr_score = 1'b0;
        paddle_y = 11'd200;
        #2 resetn = 1'b0;
        #1 check_reset_vals("por");
        repeat (2) @(posedge clk);
        #1 check_reset_vals("por_hold");
        model_reset();
        @(negedge clk) resetn = 1'b1;

        for (int cyc = 0; cyc < 85000 && n_err < 50 && done == 0; cyc++) begin
            choose_inputs();
            @(posedge clk);
            model_step(int'(start), int'(clr_score), int'(paddle_y));
            #1 compare_all();
            if (overs >= 2 && m_st == 1) done = 1;
            if (did_rst == 0 && overs >= 1 && m_st == 1 && m_x > 300) begin
                did_rst = 1;
                start = 1'b1;
                #2 resetn = 1'b0;
                #1 check_reset_vals("mid_rst");
                @(posedge clk);
                #1 check_reset_vals("mid_rst_hold");
                model_reset();
                @(negedge clk) resetn = 1'b1;
            end
        end

        check_eq("cov_paddle_hit",   32'(saw_hit),        32'd1);
        check_eq("cov_window_edge",  32'(saw_edge_nohit), 32'd1);
        check_eq("cov_miss",         32'(saw_miss),       32'd1);
        check_eq("cov_clr_on_miss",  32'(saw_clr_miss),   32'd1);
        check_eq("cov_game_over",    32'(overs >= 1),     32'd1);
        check_eq("cov_mid_reset",    32'(did_rst),        32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
